comp_csr_arbiter: RTL

//   Round-robin arbiter that shares the single comparator CSR slave among NUM_MASTERS Nios cores.

---
 rtl/comp_csr_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/comp_csr_arbiter.sv
// Round-robin share of the comparator CSR slave among NUM_MASTERS cores; IDLE->BUSY->GAP, 3 + slave-latency cycles per access.
// Losers and waiting cores see waitrequest=1; optional BUSY watchdog under `define COMP_ARB_TIMEOUT_EN.
module comp_csr_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_address,
    input  logic [NUM_MASTERS-1:0]              m_read,
    input  logic [NUM_MASTERS-1:0]              m_write,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_writedata,
    output logic [DATA_WIDTH-1:0]               m_readdata,
    output logic [NUM_MASTERS-1:0]              m_waitrequest,
    output logic [ADDR_WIDTH-1:0]               s_address,
    output logic                                s_read,
    output logic                                s_write,
    output logic [DATA_WIDTH-1:0]               s_writedata,
    input  logic [DATA_WIDTH-1:0]               s_readdata,
    input  logic                                s_waitrequest,
    output logic [$clog2(NUM_MASTERS)-1:0]      grant_id,
    output logic                                timeout_flag
);
    localparam int GW = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_GAP} state_t;

    state_t                  r_state, w_next;
    logic [GW-1:0]           r_grant, r_last, w_win, w_idx;
    logic                    w_any, w_done, w_tmo;
    logic [NUM_MASTERS-1:0]  w_req;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata, r_rdata, w_rdata_now;
    logic                    r_rd, r_wr;

    assign w_req = m_read | m_write;

    // Scan starts one past the last completed grant and wraps at NUM_MASTERS.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = r_last;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_idx = (w_idx == GW'(NUM_MASTERS - 1)) ? '0 : w_idx + 1'b1;
            if (!w_any && w_req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    assign w_done      = (r_state == ST_BUSY) && (!s_waitrequest || w_tmo);
    assign w_rdata_now = w_tmo ? DATA_WIDTH'(32'hDEAD_BEEF) : s_readdata;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any)  w_next = ST_BUSY;
            ST_BUSY: if (w_done) w_next = ST_GAP;
            ST_GAP:              w_next = ST_IDLE;
            default:             w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= GW'(NUM_MASTERS - 1);
            r_addr  <= '0;
            r_wdata <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_any) begin
                r_grant <= w_win;
                r_addr  <= m_address[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
                r_wdata <= m_writedata[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
                r_wr    <= m_write[w_win];
                r_rd    <= m_read[w_win] & ~m_write[w_win];
            end
            if (w_done) begin
                r_last  <= r_grant;
                r_rdata <= w_rdata_now;
            end
        end
    end

    always_comb begin
        m_waitrequest = '1;
        if (w_done) m_waitrequest[r_grant] = 1'b0;
    end

    assign m_readdata  = w_done ? w_rdata_now : r_rdata;
    assign s_read      = (r_state == ST_BUSY) && r_rd;
    assign s_write     = (r_state == ST_BUSY) && r_wr;
    assign s_address   = r_addr;
    assign s_writedata = r_wdata;
    assign grant_id    = r_grant;

`ifdef COMP_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_tmo_flag;

    assign w_tmo        = (r_state == ST_BUSY) && s_waitrequest && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign timeout_flag = r_tmo_flag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_tmo_flag <= 1'b0;
        end else begin
            if (r_state != ST_BUSY)
                r_cnt <= '0;
            else if (s_waitrequest && !w_tmo)
                r_cnt <= r_cnt + 1'b1;
            if (w_tmo) r_tmo_flag <= 1'b1;
        end
    end
`else
    logic w_unused;
    assign w_unused     = ^TIMEOUT_CYCLES;
    assign w_tmo        = 1'b0;
    assign timeout_flag = 1'b0;
`endif

endmodule
